// File: rtl/alu_arb.sv
// Two-requester front end for a shared ALU: arbitrates, sequences one operation
// at a time through the ALU, owns the architectural flags register and returns results.
module alu_arb #(
  parameter bit          RR          = 1'b1,
  parameter logic [11:0] FLAGS_RESET = 12'h002
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [3:0]  rq0_mode,
  input  logic        rq0_isize,
  input  logic        rq0_opsize,
  input  logic [31:0] rq0_op1,
  input  logic [31:0] rq0_op2,
  input  logic        rq0_wf,

  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [3:0]  rq1_mode,
  input  logic        rq1_isize,
  input  logic        rq1_opsize,
  input  logic [31:0] rq1_op1,
  input  logic [31:0] rq1_op2,
  input  logic        rq1_wf,

  output logic        rs_valid,
  input  logic        rs_ready,
  output logic        rs_id,
  output logic [31:0] rs_result,
  output logic [11:0] rs_flags,

  output logic        alu_isize,
  output logic        alu_opsize,
  output logic [2:0]  alu_mode,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [11:0] alu_flags,

  input  logic [31:0] alu_result,
  input  logic [11:0] alu_flags_o,
  input  logic [15:0] alu_daa_r,
  input  logic [11:0] alu_flags_d,

  output logic [11:0] flags_q,
  input  logic        flags_we,
  input  logic [11:0] flags_wd,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for a request; only state that accepts requests or flags_we
  // EXEC  | latched operation presented to the ALU; results captured at its end
  // RESP  | response held on rs_* until rs_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic        gnt_any, gnt_id, accept;
  logic        last_q, last_d;

  logic [3:0]  mode_q, mode_d;
  logic        isize_q, isize_d;
  logic        opsize_q, opsize_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        wf_q, wf_d;
  logic        id_q, id_d;

  logic [31:0] rs_result_q, rs_result_d;
  logic [11:0] rs_flags_q, rs_flags_d;
  logic        rs_id_q, rs_id_d;
  logic [11:0] flags_d;

  logic [31:0] cap_result;
  logic [11:0] cap_flags;
  logic        cap_wr;

  // With both requesting, round-robin favours whoever was not served last.
  always_comb begin
    gnt_any = rq0_valid | rq1_valid;
    gnt_id  = 1'b0;
    if (rq0_valid && rq1_valid) begin
      gnt_id = RR ? ~last_q : 1'b0;
    end else if (rq1_valid) begin
      gnt_id = 1'b1;
    end
  end

  assign accept = (state_q == S_IDLE) & ~reset & gnt_any;
  assign last_d = accept ? gnt_id : last_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rs_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rq0_ready = 1'b0;
    rq1_ready = 1'b0;
    rs_valid  = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        rq0_ready = accept & ~gnt_id;
        rq1_ready = accept & gnt_id;
      end
      S_RESP:  rs_valid = 1'b1;
      default: ;
    endcase
  end

  // Adjust modes 4-7 pass op1 through and leave the flags untouched.
  always_comb begin
    cap_result = alu_result;
    cap_flags  = alu_flags_o;
    cap_wr     = wf_q;
    if (mode_q[3]) begin
      if (!mode_q[2]) begin
        cap_result = {16'h0000, alu_daa_r};
        cap_flags  = alu_flags_d;
      end else begin
        cap_result = op1_q;
        cap_flags  = flags_q;
        cap_wr     = 1'b0;
      end
    end
  end

  always_comb begin
    mode_d      = mode_q;
    isize_d     = isize_q;
    opsize_d    = opsize_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    wf_d        = wf_q;
    id_d        = id_q;
    rs_result_d = rs_result_q;
    rs_flags_d  = rs_flags_q;
    rs_id_d     = rs_id_q;
    flags_d     = flags_q;

    if (accept) begin
      mode_d   = gnt_id ? rq1_mode   : rq0_mode;
      isize_d  = gnt_id ? rq1_isize  : rq0_isize;
      opsize_d = gnt_id ? rq1_opsize : rq0_opsize;
      op1_d    = gnt_id ? rq1_op1    : rq0_op1;
      op2_d    = gnt_id ? rq1_op2    : rq0_op2;
      wf_d     = gnt_id ? rq1_wf     : rq0_wf;
      id_d     = gnt_id;
    end

    if (state_q == S_IDLE && flags_we) begin
      flags_d = flags_wd | 12'h002;
    end

    if (state_q == S_EXEC) begin
      rs_result_d = cap_result;
      rs_flags_d  = cap_flags;
      rs_id_d     = id_q;
      if (cap_wr) begin
        flags_d = cap_flags | 12'h002;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q      <= 1'b1;
      mode_q      <= 4'h0;
      isize_q     <= 1'b0;
      opsize_q    <= 1'b0;
      op1_q       <= 32'h0;
      op2_q       <= 32'h0;
      wf_q        <= 1'b0;
      id_q        <= 1'b0;
      rs_result_q <= 32'h0;
      rs_flags_q  <= 12'h000;
      rs_id_q     <= 1'b0;
      flags_q     <= FLAGS_RESET;
    end else begin
      last_q      <= last_d;
      mode_q      <= mode_d;
      isize_q     <= isize_d;
      opsize_q    <= opsize_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      wf_q        <= wf_d;
      id_q        <= id_d;
      rs_result_q <= rs_result_d;
      rs_flags_q  <= rs_flags_d;
      rs_id_q     <= rs_id_d;
      flags_q     <= flags_d;
    end
  end

  assign alu_isize  = isize_q;
  assign alu_opsize = opsize_q;
  assign alu_mode   = mode_q[2:0];
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_flags  = flags_q;

  assign rs_result  = rs_result_q;
  assign rs_flags   = rs_flags_q;
  assign rs_id      = rs_id_q;

endmodule

// File: tb/tb_alu_arb.sv
// Bench for alu_arb: an x86-style ALU stands in for the real one, and a
// transaction-level model predicts every DUT output on every cycle.
module tb_alu_arb;

  logic        clock = 1'b0;
  logic        reset;
  logic        rq0_valid, rq0_isize, rq0_opsize, rq0_wf;
  logic [3:0]  rq0_mode;
  logic [31:0] rq0_op1, rq0_op2;
  logic        rq1_valid, rq1_isize, rq1_opsize, rq1_wf;
  logic [3:0]  rq1_mode;
  logic [31:0] rq1_op1, rq1_op2;
  logic        rq0_ready, rq1_ready;
  logic        rs_valid, rs_ready, rs_id;
  logic [31:0] rs_result;
  logic [11:0] rs_flags;
  logic        alu_isize, alu_opsize;
  logic [2:0]  alu_mode;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [11:0] alu_flags, alu_flags_o, alu_flags_d;
  logic [15:0] alu_daa_r;
  logic [11:0] flags_q, flags_wd;
  logic        flags_we, busy;

  logic        fp_rq0_ready, fp_rq1_ready, fp_rs_valid, fp_rs_id, fp_busy;
  logic        fp_alu_isize, fp_alu_opsize;
  logic [2:0]  fp_alu_mode;
  logic [31:0] fp_rs_result, fp_alu_op1, fp_alu_op2;
  logic [11:0] fp_rs_flags, fp_alu_flags, fp_flags_q;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clock = ~clock;

  alu_arb #(.RR(1'b1), .FLAGS_RESET(12'h002)) dut (
    .clock(clock), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_mode(rq0_mode), .rq0_isize(rq0_isize),
    .rq0_opsize(rq0_opsize), .rq0_op1(rq0_op1), .rq0_op2(rq0_op2), .rq0_wf(rq0_wf),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_mode(rq1_mode), .rq1_isize(rq1_isize),
    .rq1_opsize(rq1_opsize), .rq1_op1(rq1_op1), .rq1_op2(rq1_op2), .rq1_wf(rq1_wf),
    .rs_valid(rs_valid), .rs_ready(rs_ready), .rs_id(rs_id), .rs_result(rs_result), .rs_flags(rs_flags),
    .alu_isize(alu_isize), .alu_opsize(alu_opsize), .alu_mode(alu_mode), .alu_op1(alu_op1),
    .alu_op2(alu_op2), .alu_flags(alu_flags), .alu_result(alu_result), .alu_flags_o(alu_flags_o),
    .alu_daa_r(alu_daa_r), .alu_flags_d(alu_flags_d),
    .flags_q(flags_q), .flags_we(flags_we), .flags_wd(flags_wd), .busy(busy)
  );

  // Fixed-priority twin, only its grant order is of interest.
  alu_arb #(.RR(1'b0), .FLAGS_RESET(12'h002)) u_fp (
    .clock(clock), .reset(reset),
    .rq0_valid(rq0_valid), .rq0_ready(fp_rq0_ready), .rq0_mode(rq0_mode), .rq0_isize(rq0_isize),
    .rq0_opsize(rq0_opsize), .rq0_op1(rq0_op1), .rq0_op2(rq0_op2), .rq0_wf(rq0_wf),
    .rq1_valid(rq1_valid), .rq1_ready(fp_rq1_ready), .rq1_mode(rq1_mode), .rq1_isize(rq1_isize),
    .rq1_opsize(rq1_opsize), .rq1_op1(rq1_op1), .rq1_op2(rq1_op2), .rq1_wf(rq1_wf),
    .rs_valid(fp_rs_valid), .rs_ready(rs_ready), .rs_id(fp_rs_id), .rs_result(fp_rs_result),
    .rs_flags(fp_rs_flags), .alu_isize(fp_alu_isize), .alu_opsize(fp_alu_opsize), .alu_mode(fp_alu_mode),
    .alu_op1(fp_alu_op1), .alu_op2(fp_alu_op2), .alu_flags(fp_alu_flags), .alu_result(32'h0),
    .alu_flags_o(12'h0), .alu_daa_r(16'h0), .alu_flags_d(12'h0),
    .flags_q(fp_flags_q), .flags_we(flags_we), .flags_wd(flags_wd), .busy(fp_busy)
  );

  // ---------------- reference ALU (x86 flag layout: C=0 P=2 A=4 Z=6 S=7 O=11) ----------------
  function automatic logic [43:0] alu_fn(input logic [2:0] m, input logic is, input logic os,
                                         input logic [31:0] a_i, input logic [31:0] b_i, input logic [11:0] f);
    logic [31:0] mask, a, b, r, msbm;
    logic [32:0] full;
    logic        sub, lg, sa, sb, sr, of;
    logic [11:0] fo;
    int          w;
    w    = is ? (os ? 32 : 16) : 8;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    msbm = 32'd1 << (w - 1);
    a = a_i & mask;
    b = b_i & mask;
    sub = 1'b0;
    lg  = 1'b0;
    case (m)
      3'd0: full = {1'b0, a} + {1'b0, b};
      3'd1: begin full = {1'b0, a | b}; lg = 1'b1; end
      3'd2: full = {1'b0, a} + {1'b0, b} + {32'd0, f[0]};
      3'd3: begin full = {1'b0, a} - {1'b0, b} - {32'd0, f[0]}; sub = 1'b1; end
      3'd4: begin full = {1'b0, a & b}; lg = 1'b1; end
      3'd5: begin full = {1'b0, a} - {1'b0, b}; sub = 1'b1; end
      3'd6: begin full = {1'b0, a ^ b}; lg = 1'b1; end
      default: begin full = {1'b0, a} - {1'b0, b}; sub = 1'b1; end
    endcase
    r  = full[31:0] & mask;
    sa = |(a & msbm);
    sb = |(b & msbm);
    sr = |(r & msbm);
    of = lg ? 1'b0 : (sub ? (sa != sb && sr != sa) : (sa == sb && sr != sa));
    fo     = f;
    fo[0]  = lg ? 1'b0 : |(full & (33'd1 << w));
    fo[1]  = 1'b1;
    fo[2]  = ~^r[7:0];
    fo[4]  = lg ? 1'b0 : (a[4] ^ b[4] ^ r[4]);
    fo[6]  = (r == 32'h0);
    fo[7]  = sr;
    fo[11] = of;
    return {fo, r};
  endfunction

  function automatic logic [27:0] adj_fn(input logic [1:0] m, input logic [15:0] ax, input logic [11:0] f);
    logic [7:0]  al, ah, old_al;
    logic        cf, af, old_cf;
    logic [11:0] fo;
    al = ax[7:0];
    ah = ax[15:8];
    old_al = al;
    old_cf = f[0];
    af = f[4];
    cf = 1'b0;
    case (m)
      2'd0: begin
        if (al[3:0] > 4'd9 || af) begin al = al + 8'h06; af = 1'b1; end else af = 1'b0;
        if (old_al > 8'h99 || old_cf) begin al = al + 8'h60; cf = 1'b1; end else cf = 1'b0;
      end
      2'd1: begin
        if (al[3:0] > 4'd9 || af) begin al = al - 8'h06; af = 1'b1; end else af = 1'b0;
        if (old_al > 8'h99 || old_cf) begin al = al - 8'h60; cf = 1'b1; end else cf = 1'b0;
      end
      2'd2: begin
        if (al[3:0] > 4'd9 || af) begin al = al + 8'h06; ah = ah + 8'h01; af = 1'b1; cf = 1'b1; end
        else begin af = 1'b0; cf = 1'b0; end
        al = {4'h0, al[3:0]};
      end
      default: begin
        if (al[3:0] > 4'd9 || af) begin al = al - 8'h06; ah = ah - 8'h01; af = 1'b1; cf = 1'b1; end
        else begin af = 1'b0; cf = 1'b0; end
        al = {4'h0, al[3:0]};
      end
    endcase
    fo    = f;
    fo[0] = cf;
    fo[1] = 1'b1;
    fo[2] = ~^al;
    fo[4] = af;
    fo[6] = (al == 8'h00);
    fo[7] = al[7];
    return {fo, ah, al};
  endfunction

  always_comb begin
    {alu_flags_o, alu_result} = alu_fn(alu_mode, alu_isize, alu_opsize, alu_op1, alu_op2, alu_flags);
    {alu_flags_d, alu_daa_r}  = adj_fn(alu_mode[1:0], alu_op1[15:0], alu_flags);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------------
  int          cyc = 0;
  int          m_due = 0;
  bit          m_inflight = 1'b0;
  logic        m_last = 1'b1, m_id = 1'b0, p_id;
  logic [31:0] m_res = 32'h0, p_res;
  logic [11:0] m_rflags = 12'h0, p_rflags, m_flags = 12'h002;
  bit          p_wr;

  always @(negedge clock) begin
    logic        g_any, g_id, wf;
    logic [3:0]  md;
    logic [31:0] a, b;
    logic        is, os;
    cyc++;
    g_any = !reset && !m_inflight && (rq0_valid || rq1_valid);
    g_id  = (rq0_valid && rq1_valid) ? !m_last : rq1_valid;
    if (chk_en) begin
      chk("rq0_ready", 32'(rq0_ready), 32'(g_any && !g_id));
      chk("rq1_ready", 32'(rq1_ready), 32'(g_any && g_id));
      chk("busy", 32'(busy), 32'(m_inflight));
      chk("rs_valid", 32'(rs_valid), 32'(m_inflight && cyc >= m_due));
      chk("rs_result", rs_result, m_res);
      chk("rs_flags", 32'(rs_flags), 32'(m_rflags));
      chk("rs_id", 32'(rs_id), 32'(m_id));
      chk("flags_q", 32'(flags_q), 32'(m_flags));
    end
    if (reset) begin
      m_inflight = 1'b0;
      m_flags    = 12'h002;
      m_last     = 1'b1;
      m_res      = 32'h0;
      m_rflags   = 12'h0;
      m_id       = 1'b0;
    end else if (m_inflight) begin
      if (cyc == m_due - 1) begin
        m_res    = p_res;
        m_rflags = p_rflags;
        m_id     = p_id;
        if (p_wr) m_flags = p_flags_or2(p_rflags);
      end
      if (cyc >= m_due && rs_ready) m_inflight = 1'b0;
    end else begin
      if (flags_we) m_flags = flags_wd | 12'h002;
      if (g_any) begin
        md = g_id ? rq1_mode : rq0_mode;
        is = g_id ? rq1_isize : rq0_isize;
        os = g_id ? rq1_opsize : rq0_opsize;
        a  = g_id ? rq1_op1 : rq0_op1;
        b  = g_id ? rq1_op2 : rq0_op2;
        wf = g_id ? rq1_wf : rq0_wf;
        if (!md[3]) begin
          {p_rflags, p_res} = alu_fn(md[2:0], is, os, a, b, m_flags);
          p_wr = wf;
        end else if (!md[2]) begin
          {p_rflags, p_res[15:0]} = adj_fn(md[1:0], a[15:0], m_flags);
          p_res[31:16] = 16'h0;
          p_wr = wf;
        end else begin
          p_res    = a;
          p_rflags = m_flags;
          p_wr     = 1'b0;
        end
        p_id       = g_id;
        m_last     = g_id;
        m_inflight = 1'b1;
        m_due      = cyc + 2;
      end
    end
  end

  function automatic logic [11:0] p_flags_or2(input logic [11:0] f);
    return f | 12'h002;
  endfunction

  // ---------------- stimulus ----------------
  task automatic issue(input int n, input logic [3:0] md, input logic is, input logic os,
                       input logic [31:0] a, input logic [31:0] b, input logic wf);
    bit got;
    @(posedge clock); #1;
    if (n == 0) begin
      rq0_mode = md; rq0_isize = is; rq0_opsize = os; rq0_op1 = a; rq0_op2 = b; rq0_wf = wf; rq0_valid = 1'b1;
    end else begin
      rq1_mode = md; rq1_isize = is; rq1_opsize = os; rq1_op1 = a; rq1_op2 = b; rq1_wf = wf; rq1_valid = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clock);
      got = (n == 0) ? rq0_ready : rq1_ready;
    end
    n_total++;
    if (!got) $display("FAIL accept_timeout: got no ready expected ready on rq%0d", n);
    else n_pass++;
    @(posedge clock); #1;
    if (n == 0) rq0_valid = 1'b0; else rq1_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cnt, ng, nf;
    logic ids[4];
    logic fids[4];
    reset = 1'b1; rs_ready = 1'b1; flags_we = 1'b0; flags_wd = 12'h0;
    rq0_valid = 1'b0; rq0_mode = 4'h0; rq0_isize = 1'b0; rq0_opsize = 1'b0; rq0_op1 = 0; rq0_op2 = 0; rq0_wf = 1'b0;
    rq1_valid = 1'b0; rq1_mode = 4'h0; rq1_isize = 1'b0; rq1_opsize = 1'b0; rq1_op1 = 0; rq1_op2 = 0; rq1_wf = 1'b0;
    @(posedge clock); #1 chk_en = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rs_valid", 32'(rs_valid), 32'h0);
    chk("reset_flags", 32'(flags_q), 32'h002);
    chk("reset_rs_result", rs_result, 32'h0);

    // byte ADD FF+01 with flag write
    issue(0, 4'h0, 1'b0, 1'b0, 32'hFF, 32'h01, 1'b1);
    @(negedge clock);
    chk("add_exec_rs_valid", 32'(rs_valid), 32'h0);
    @(negedge clock);
    chk("add_rs_valid", 32'(rs_valid), 32'h1);
    chk("add_result", rs_result, 32'h0);
    chk("add_rs_flags", 32'(rs_flags), 32'h057);
    chk("add_flags_q", 32'(flags_q), 32'h057);
    chk("add_rs_id", 32'(rs_id), 32'h0);

    // ADC with carry in via flags_we
    @(posedge clock); #1 flags_we = 1'b1; flags_wd = 12'h003;
    @(posedge clock); #1 flags_we = 1'b0;
    issue(0, 4'h2, 1'b1, 1'b0, 32'h1234, 32'h0001, 1'b1);
    repeat (2) @(negedge clock);
    chk("adc_result", rs_result, 32'h1236);
    chk("adc_carry", 32'(rs_flags[0]), 32'h0);

    // DAA on requester 1
    @(posedge clock); #1 flags_we = 1'b1; flags_wd = 12'h002;
    @(posedge clock); #1 flags_we = 1'b0;
    issue(1, 4'h8, 1'b0, 1'b0, 32'h0F, 32'h0, 1'b1);
    repeat (2) @(negedge clock);
    chk("daa_result", rs_result, 32'h15);
    chk("daa_af", 32'(rs_flags[4]), 32'h1);
    chk("daa_cf", 32'(rs_flags[0]), 32'h0);
    chk("daa_id", 32'(rs_id), 32'h1);

    // adjust 4-7 passes op1 through
    issue(0, 4'hC, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b1);
    repeat (2) @(negedge clock);
    chk("pass_result", rs_result, 32'hDEAD_BEEF);

    // assorted operations, checked by the model
    issue(0, 4'h5, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0002, 1'b1); repeat (2) @(negedge clock);
    issue(1, 4'h3, 1'b1, 1'b0, 32'h0000_8000, 32'h0000_0001, 1'b1); repeat (2) @(negedge clock);
    issue(0, 4'h7, 1'b0, 1'b0, 32'h7F, 32'h80, 1'b1);                repeat (2) @(negedge clock);
    issue(1, 4'h4, 1'b1, 1'b0, 32'hF0F0, 32'h0FF0, 1'b0);            repeat (2) @(negedge clock);
    issue(0, 4'h1, 1'b1, 1'b1, 32'h8000_0000, 32'h1, 1'b1);          repeat (2) @(negedge clock);
    issue(1, 4'h6, 1'b0, 1'b0, 32'hAA, 32'hAA, 1'b1);                repeat (2) @(negedge clock);
    issue(0, 4'h9, 1'b0, 1'b0, 32'h9B, 32'h0, 1'b1);                 repeat (2) @(negedge clock);
    issue(1, 4'hA, 1'b0, 1'b0, 32'h010B, 32'h0, 1'b1);               repeat (2) @(negedge clock);
    issue(0, 4'hB, 1'b0, 1'b0, 32'h0200, 32'h0, 1'b1);               repeat (2) @(negedge clock);

    // arbitration with both requesters held valid, starting from reset
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    rq0_mode = 4'h0; rq0_isize = 1'b0; rq0_opsize = 1'b0; rq0_op1 = 32'h10; rq0_op2 = 32'h20; rq0_wf = 1'b1;
    rq1_mode = 4'h5; rq1_isize = 1'b1; rq1_opsize = 1'b0; rq1_op1 = 32'h100; rq1_op2 = 32'h1; rq1_wf = 1'b0;
    rq0_valid = 1'b1; rq1_valid = 1'b1;
    ng = 0; nf = 0;
    for (int k = 0; k < 40 && (ng < 4 || nf < 4); k++) begin
      @(negedge clock);
      if ((rq0_ready || rq1_ready) && ng < 4) begin ids[ng] = rq1_ready; ng++; end
      if ((fp_rq0_ready || fp_rq1_ready) && nf < 4) begin fids[nf] = fp_rq1_ready; nf++; end
    end
    @(posedge clock); #1 rq0_valid = 1'b0; rq1_valid = 1'b0;
    chk("rr_grants", 32'(ng), 32'd4);
    chk("fp_grants", 32'(nf), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_id%0d", k), 32'(ids[k]), 32'(k % 2));
      chk($sformatf("fp_id%0d", k), 32'(fids[k]), 32'h0);
    end
    repeat (3) @(negedge clock);

    // reset during EXEC aborts the operation
    issue(0, 4'h0, 1'b0, 1'b0, 32'h80, 32'h80, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_rs_valid", 32'(rs_valid), 32'h0);
    chk("abort_flags", 32'(flags_q), 32'h002);
    cnt = 0;
    repeat (6) begin @(negedge clock); if (rs_valid) cnt++; end
    chk("abort_no_resp", 32'(cnt), 32'h0);

    // response back-pressure; a waiting request and flags_we are held off
    @(posedge clock); #1 rs_ready = 1'b0;
    issue(1, 4'h6, 1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_0000, 1'b1);
    rq0_mode = 4'h0; rq0_isize = 1'b1; rq0_opsize = 1'b0; rq0_op1 = 32'h7FFF; rq0_op2 = 32'h1; rq0_wf = 1'b1;
    rq0_valid = 1'b1;
    flags_we = 1'b1; flags_wd = 12'hFFF;
    cnt = 0;
    repeat (6) begin @(negedge clock); if (rs_valid) cnt++; end
    chk("hold_cycles", 32'(cnt), 32'd5);
    @(posedge clock); #1 rs_ready = 1'b1; flags_we = 1'b0;
    @(negedge clock);
    chk("hold_still_valid", 32'(rs_valid), 32'h1);
    @(negedge clock);
    chk("release_busy", 32'(busy), 32'h0);
    chk("release_rq0_ready", 32'(rq0_ready), 32'h1);
    @(posedge clock); #1 rq0_valid = 1'b0;
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
